// File: rtl/rr_grant_responder.sv
// rr_grant_responder: target end of a 4-client round-robin handshake; acks one-hot grants,
// queues the granted payload in a FIFO, drains it over valid/ready, counts accepts per client.
module rr_grant_responder #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_an,
    input  logic [3:0]                 grant,
    input  logic [4*DW-1:0]            req_data,
    output logic [3:0]                 ack,
    output logic                       out_valid,
    output logic [DW-1:0]              out_data,
    output logic [1:0]                 out_id,
    input  logic                       out_ready,
    input  logic                       clr,
    output logic [4*CW-1:0]            acc_cnt,
    output logic                       grant_err,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [DW-1:0] data_mem [DEPTH];
    logic [1:0]    id_mem   [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt [4];
    logic          multi, onehot, pop, accept;
    logic [1:0]    id;
    logic [DW-1:0] sel;

    // A full FIFO still accepts when the head leaves on the same edge.
    always_comb begin
        out_valid = level != '0;
        out_data  = data_mem[rd_ptr];
        out_id    = id_mem[rd_ptr];
        multi     = (grant & (grant - 4'd1)) != 4'd0;
        onehot    = (grant != 4'd0) && !multi;
        pop       = out_valid & out_ready;
        accept    = onehot & ((level != FULL) | pop);
        ack       = accept ? grant : 4'd0;
        id        = {grant[3] | grant[2], grant[3] | grant[1]};
        sel       = req_data[id*DW +: DW];
        for (int i = 0; i < 4; i++) acc_cnt[i*CW +: CW] = cnt[i];
    end

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                id_mem[i]   <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept) begin
                data_mem[wr_ptr] <= sel;
                id_mem[wr_ptr]   <= id;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept != pop) level <= accept ? level + 1'b1 : level - 1'b1;
        end
    end

    // clr wins over a same-edge increment or error set.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            grant_err <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            grant_err <= 1'b0;
        end else begin
            if (accept && cnt[id] != '1) cnt[id] <= cnt[id] + 1'b1;
            if (multi) grant_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rr_grant_responder.sv
// tb_rr_grant_responder: directed scenarios with hand-computed expectations for rr_grant_responder.
module tb_rr_grant_responder;
    logic        clk = 1'b0;
    logic        rst_an;
    logic [3:0]  grant;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        clr;
    logic [31:0] acc_cnt;
    logic        grant_err;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_cnt [4];

    rr_grant_responder #(.DW(8), .DEPTH(4), .CW(8)) dut (
        .clk(clk), .rst_an(rst_an), .grant(grant), .req_data(req_data), .ack(ack),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
        .clr(clr), .acc_cnt(acc_cnt), .grant_err(grant_err), .level(level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_counts(input string name);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (acc_cnt[c*8 +: 8] !== exp_cnt[c]) begin
                errors++;
                $display("FAIL %s acc_cnt[%0d] got %0d expected %0d", name, c, acc_cnt[c*8 +: 8], exp_cnt[c]);
            end
        end
    endtask

    task automatic test_reset;
        rst_an = 1'b0; grant = 4'd0; req_data = '0; out_ready = 1'b0; clr = 1'b0;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 8'd0;
        tick; tick;
        checks++;
        if ({out_valid, level, out_data, out_id, grant_err, ack} !== 17'd0) begin
            errors++;
            $display("FAIL reset valid=%b level=%0d data=%h id=%0d err=%b ack=%b expected all zero",
                     out_valid, level, out_data, out_id, grant_err, ack);
        end
        test_counts("reset");
        rst_an = 1'b1;
        tick;
    endtask

    task automatic test_single;
        grant = 4'b0100; req_data[16 +: 8] = 8'hA5; #1;
        checks++;
        if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b expected 0100", ack); end
        tick; grant = 4'd0; exp_cnt[2]++;
        checks++;
        if ({out_valid, out_data, out_id, level} !== {1'b1, 8'hA5, 2'd2, 3'd1}) begin
            errors++;
            $display("FAIL single_out valid=%b data=%h id=%0d level=%0d expected 1 a5 2 1", out_valid, out_data, out_id, level);
        end
        test_counts("single");
        out_ready = 1'b1; tick; out_ready = 1'b0;
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL single_drain level got %0d expected 0", level); end
    endtask

    task automatic test_full;
        logic [7:0] d [4];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            grant = 4'b0001 << i; req_data[i*8 +: 8] = d[i]; #1;
            checks++;
            if (ack !== grant) begin errors++; $display("FAIL fill_ack[%0d] got %b expected %b", i, ack, grant); end
            tick; exp_cnt[i]++;
        end
        grant = 4'b0001; req_data[7:0] = 8'h55; #1;
        checks++;
        if (ack !== 4'd0) begin errors++; $display("FAIL full_ack got %b expected 0000", ack); end
        tick; grant = 4'd0;
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d expected 4", level); end
        test_counts("full");
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_data, out_id} !== {1'b1, d[i], 2'(i)}) begin
                errors++;
                $display("FAIL drain[%0d] valid=%b data=%h id=%0d expected 1 %h %0d", i, out_valid, out_data, out_id, d[i], i);
            end
            tick;
        end
        tick;
        checks++;
        if ({out_valid, level} !== 4'd0) begin
            errors++;
            $display("FAIL empty_ready valid=%b level=%0d expected 0 0", out_valid, level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop;
        logic [7:0] d [4];
        logic [1:0] ids [4];
        d[0] = 8'hA2; d[1] = 8'hA3; d[2] = 8'hA4; d[3] = 8'h77;
        ids[0] = 2'd1; ids[1] = 2'd2; ids[2] = 2'd3; ids[3] = 2'd3;
        for (int i = 0; i < 4; i++) begin
            grant = 4'b0001 << i; req_data[i*8 +: 8] = 8'hA1 + 8'(i);
            tick; exp_cnt[i]++;
        end
        out_ready = 1'b1; grant = 4'b1000; req_data[24 +: 8] = 8'h77; #1;
        checks++;
        if (ack !== 4'b1000) begin errors++; $display("FAIL fullpop_ack got %b expected 1000", ack); end
        tick; grant = 4'd0; exp_cnt[3]++;
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d expected 4", level); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_valid, out_data, out_id} !== {1'b1, d[i], ids[i]}) begin
                errors++;
                $display("FAIL fullpop_drain[%0d] valid=%b data=%h id=%0d expected 1 %h %0d", i, out_valid, out_data, out_id, d[i], ids[i]);
            end
            tick;
        end
        out_ready = 1'b0;
        test_counts("fullpop");
    endtask

    task automatic test_error;
        grant = 4'b0010; req_data[8 +: 8] = 8'h5A; tick; exp_cnt[1]++;
        grant = 4'b0011; #1;
        checks++;
        if (ack !== 4'd0) begin errors++; $display("FAIL multi_ack got %b expected 0000", ack); end
        tick; grant = 4'd0;
        checks++;
        if ({grant_err, level} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL multi_err err=%b level=%0d expected 1 1", grant_err, level);
        end
        tick;
        checks++;
        if (grant_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", grant_err); end
        test_counts("multi");
        clr = 1'b1; grant = 4'b0101; tick;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 8'd0;
        checks++;
        if ({grant_err, level, out_data, out_id} !== {1'b0, 3'd1, 8'h5A, 2'd1}) begin
            errors++;
            $display("FAIL clr err=%b level=%0d data=%h id=%0d expected 0 1 5a 1", grant_err, level, out_data, out_id);
        end
        test_counts("clr");
        grant = 4'b0001; req_data[7:0] = 8'hC1; tick;
        clr = 1'b0; grant = 4'd0;
        checks++;
        if (level !== 3'd2) begin errors++; $display("FAIL clr_push level got %0d expected 2", level); end
        test_counts("clr_incr");
        out_ready = 1'b1; tick; tick; out_ready = 1'b0;
    endtask

    task automatic test_saturate;
        int pops = 0;
        int bad = 0;
        grant = 4'b0001; req_data[7:0] = 8'h3C; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (ack !== 4'b0001) bad++;
            if (out_valid) begin
                pops++;
                if (out_id !== 2'd0 || out_data !== 8'h3C) bad++;
            end
            tick;
        end
        grant = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) begin
                pops++;
                if (out_id !== 2'd0) bad++;
            end
            tick;
        end
        exp_cnt[0] = 8'd255;
        checks++;
        if (pops != 300 || bad != 0) begin
            errors++;
            $display("FAIL saturate_stream pops=%0d bad=%0d expected 300 0", pops, bad);
        end
        test_counts("saturate");
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) begin
            grant = 4'b0001 << i; req_data[i*8 +: 8] = 8'h91 + 8'(i); tick;
        end
        grant = 4'd0;
        checks++;
        if (level !== 3'd3) begin errors++; $display("FAIL pre_reset level got %0d expected 3", level); end
        #2 rst_an = 1'b0; #1;
        for (int c = 0; c < 4; c++) exp_cnt[c] = 8'd0;
        checks++;
        if ({out_valid, level, grant_err} !== 5'd0) begin
            errors++;
            $display("FAIL async_reset valid=%b level=%0d err=%b expected 0 0 0", out_valid, level, grant_err);
        end
        test_counts("async_reset");
        #1 rst_an = 1'b1;
        tick;
        grant = 4'b1000; req_data[24 +: 8] = 8'hD4; tick; grant = 4'd0;
        checks++;
        if ({out_valid, out_data, out_id, level} !== {1'b1, 8'hD4, 2'd3, 3'd1}) begin
            errors++;
            $display("FAIL post_reset valid=%b data=%h id=%0d level=%0d expected 1 d4 3 1", out_valid, out_data, out_id, level);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_full;
        test_full_pop;
        test_error;
        test_saturate;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
